// File: rtl/am_score_argmax_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_score_argmax_if : controller/AND-array side bundle of am_score_argmax |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface am_score_argmax_if #(
  parameter int DIMS_PER_CC     = 64,
  parameter int SEQ_CYCLE_COUNT = 10,
  parameter int NUM_CLASSES     = 26
);
  localparam int SCORE_W = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1);

  logic                   start;
  logic                   seg_valid;
  logic [DIMS_PER_CC-1:0] and_array_in [0:NUM_CLASSES-1];
  logic [3:0]             query_ctr;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [4:0]             result_class;
  logic [SCORE_W-1:0]     result_score;

  modport master (
    output start, seg_valid, and_array_in, result_ready,
    input  query_ctr, busy, result_valid, result_class, result_score
  );

  modport slave (
    input  start, seg_valid, and_array_in, result_ready,
    output query_ctr, busy, result_valid, result_class, result_score
  );
endinterface
`default_nettype wire

// File: rtl/am_score_argmax.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_score_argmax : per-class popcount accumulation and sequential argmax  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module am_score_argmax #(
  parameter int DIMS_PER_CC     = 64,
  parameter int SEQ_CYCLE_COUNT = 10,
  parameter int NUM_CLASSES     = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  am_score_argmax_if.slave    bus
);
  localparam int SCORE_W = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         query_ctr_q, query_ctr_d;
  logic [4:0]         idx_q, idx_d;
  logic [4:0]         best_class_q, best_class_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [SCORE_W-1:0] acc_q [NUM_CLASSES];
  logic [SCORE_W-1:0] acc_d [NUM_CLASSES];
  logic [SCORE_W-1:0] seg_pop [NUM_CLASSES];
  logic [SCORE_W-1:0] acc_sel;

  // Popcount of the current segment, already widened to the accumulator width
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      seg_pop[i] = '0;
      for (int b = 0; b < DIMS_PER_CC; b++) begin
        seg_pop[i] = seg_pop[i] + SCORE_W'(bus.and_array_in[i][b]);
      end
    end
  end

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx_q == 5'(i)) acc_sel = acc_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    query_ctr_d  = query_ctr_q;
    idx_d        = idx_q;
    best_class_d = best_class_q;
    best_score_d = best_score_q;
    for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = acc_q[i];

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = '0;
          query_ctr_d = '0;
          state_d     = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.seg_valid) begin
          for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = acc_q[i] + seg_pop[i];
          if (query_ctr_q == 4'(SEQ_CYCLE_COUNT - 1)) begin
            query_ctr_d = '0;
            idx_d       = '0;
            state_d     = ST_SEARCH;
          end else begin
            query_ctr_d = query_ctr_q + 4'd1;
          end
        end
      end
      ST_SEARCH: begin
        // Strict compare keeps the lowest index on ties
        if ((idx_q == 5'd0) || (acc_sel > best_score_q)) begin
          best_score_d = acc_sel;
          best_class_d = idx_q;
        end
        if (idx_q == 5'(NUM_CLASSES - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (bus.result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      query_ctr_q  <= '0;
      idx_q        <= '0;
      best_class_q <= '0;
      best_score_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      query_ctr_q  <= query_ctr_d;
      idx_q        <= idx_d;
      best_class_q <= best_class_d;
      best_score_q <= best_score_d;
      for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.query_ctr    = query_ctr_q;
  assign bus.busy         = (state_q == ST_ACCUM) | (state_q == ST_SEARCH);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.result_class = best_class_q;
  assign bus.result_score = best_score_q;

endmodule
`default_nettype wire

// File: tb/tb_am_score_argmax.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_am_score_argmax : directed + randomized bench with popcount/argmax    |
// | reference model. Revision : 1.0                                          |
// +--------------------------------------------------------------------------+
module tb_am_score_argmax;
  localparam int DIMS = 8;
  localparam int SEQ  = 10;
  localparam int NC   = 26;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  am_score_argmax_if #(.DIMS_PER_CC(DIMS), .SEQ_CYCLE_COUNT(SEQ), .NUM_CLASSES(NC)) bus ();

  am_score_argmax #(.DIMS_PER_CC(DIMS), .SEQ_CYCLE_COUNT(SEQ), .NUM_CLASSES(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int              tests = 0;
  int              fails = 0;
  logic [DIMS-1:0] mem [SEQ][NC];
  int              exp_class;
  int              exp_score;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // row < 0 drives junk that the block must ignore
  task automatic drive_row(input int row);
    for (int c = 0; c < NC; c++)
      bus.and_array_in[c] = (row >= 0) ? mem[row][c] : DIMS'($urandom);
  endtask

  // Scores are total set bits per class; winner is the first class with the max score
  task automatic model();
    int best;
    best = -1;
    for (int c = 0; c < NC; c++) begin
      int sc;
      sc = 0;
      for (int g = 0; g < SEQ; g++) sc += $countones(mem[g][c]);
      if (sc > best) begin
        best      = sc;
        exp_class = c;
      end
    end
    exp_score = best;
  endtask

  task automatic fill(input logic [DIMS-1:0] dflt);
    for (int g = 0; g < SEQ; g++)
      for (int c = 0; c < NC; c++) mem[g][c] = dflt;
  endtask

  task automatic fill_random();
    for (int g = 0; g < SEQ; g++)
      for (int c = 0; c < NC; c++) mem[g][c] = DIMS'($urandom);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.result_valid), 0);
    chk({tag, "_qctr"}, 32'(bus.query_ctr), 0);
  endtask

  // Runs one query; returns with the result either accepted (hold_ready) or pending in DONE
  task automatic run_query(input string tag, input int gap_at, input int gap_len, input bit hold_ready);
    int seg, gap_left, lat, t, row;
    bit got, sv;
    model();
    lat              = SEQ + NC + gap_len;
    bus.result_ready = hold_ready;
    bus.seg_valid    = 1'b1;
    bus.start        = 1'b1;
    drive_row(-1);
    step();
    bus.start = 1'b0;
    seg       = 0;
    gap_left  = gap_len;
    t         = 0;
    got       = 1'b0;
    while (!got && t < lat + 8) begin
      chk({tag, "_qctr"}, 32'(bus.query_ctr), (seg < SEQ) ? seg : 0);
      if (bus.result_valid) begin
        got = 1'b1;
      end else begin
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        if (seg < SEQ) begin
          sv = !(seg == gap_at && gap_left > 0);
          if (!sv) gap_left--;
          row = (sv && bus.query_ctr < SEQ) ? int'(bus.query_ctr) : -1;
        end else begin
          sv  = 1'($urandom);
          row = -1;
        end
        bus.seg_valid = sv;
        drive_row(row);
        bus.start = 1'($urandom_range(0, 3) == 0) && (seg >= SEQ);
        step();
        bus.start = 1'b0;
        t++;
        if (sv && seg < SEQ) seg++;
      end
    end
    chk({tag, "_latency"}, got ? t : -1, lat);
    chk({tag, "_class"}, 32'(bus.result_class), exp_class);
    chk({tag, "_score"}, 32'(bus.result_score), exp_score);
    chk({tag, "_busy_done"}, 32'(bus.busy), 0);
    if (hold_ready) begin
      step();
      check_idle({tag, "_accept"});
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.seg_valid    = 1'b0;
    bus.result_ready = 1'b0;
    fill('0);
    drive_row(-1);
    step();
    step();
    check_idle("reset");
    chk("reset_class", 32'(bus.result_class), 0);
    chk("reset_score", 32'(bus.result_score), 0);
    rst_n = 1'b1;
    step();
    check_idle("idle_hold");

    // All-zero data: class 0, score 0, 36-cycle latency
    fill('0);
    run_query("zero", -1, 0, 1'b1);

    // Single strong class
    fill(8'h0F);
    for (int g = 0; g < SEQ; g++) mem[g][7] = 8'hFF;
    run_query("c7", -1, 0, 1'b1);
    chk("c7_abs_class", 32'(bus.result_class), 7);
    chk("c7_abs_score", 32'(bus.result_score), 80);

    // Tie between classes 3 and 20 resolves low
    fill('0);
    for (int g = 0; g < SEQ; g++) begin
      mem[g][3]  = 8'hF0;
      mem[g][20] = 8'hF0;
    end
    run_query("tie", -1, 0, 1'b1);
    chk("tie_abs_class", 32'(bus.result_class), 3);
    chk("tie_abs_score", 32'(bus.result_score), 40);

    // Three-cycle seg_valid gap at segment 4, then the same data without a gap
    fill_random();
    run_query("gap", 4, 3, 1'b1);
    run_query("nogap", -1, 0, 1'b1);

    // Reset mid-accumulation, then a clean query
    fill(8'hFF);
    bus.result_ready = 1'b1;
    bus.seg_valid    = 1'b1;
    bus.start        = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 20 && bus.query_ctr != 4'd6; k++) begin
      drive_row(int'(bus.query_ctr));
      step();
    end
    chk("abort_reach6", 32'(bus.query_ctr), 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle("abort");
    chk("abort_class", 32'(bus.result_class), 0);
    chk("abort_score", 32'(bus.result_score), 0);
    fill_random();
    run_query("post_abort", -1, 0, 1'b1);

    // DONE holds while result_ready is low; starts there are dropped
    fill_random();
    run_query("hold", -1, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 1 || k == 3);
      step();
      bus.start = 1'b0;
      chk("hold_valid", 32'(bus.result_valid), 1);
      chk("hold_class", 32'(bus.result_class), exp_class);
      chk("hold_score", 32'(bus.result_score), exp_score);
    end
    bus.result_ready = 1'b1;
    step();
    check_idle("hold_release");
    step();
    check_idle("hold_no_queued_start");

    // A few more random queries, with a random gap
    for (int n = 0; n < 3; n++) begin
      fill_random();
      run_query("rand", $urandom_range(0, SEQ - 1), $urandom_range(0, 4), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/am_score_argmax.md
Name: am_score_argmax

Overview:
- Downstream stage of the associative-memory AND array.
- Drives the segment counter (query_ctr) into the AND array and consumes its 26 per-class AND vectors, one segment per cycle.
- Accumulates a per-class popcount over all SEQ_CYCLE_COUNT segments, then runs a sequential argmax.
- Returns the winning class index and score to the controller over a valid/ready handshake.

Parameters:
- DIMS_PER_CC, 64, bits per segment, matching the AND array segment width.
- SEQ_CYCLE_COUNT, 10, segments per query. Legal range 1..16.
- NUM_CLASSES, 26, number of class hypervectors.
- SCORE_W, $clog2(DIMS_PER_CC*SEQ_CYCLE_COUNT+1), accumulator/score width. Derived; not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a query; accepted only in IDLE.
- seg_valid  in  1  the current segment's AND outputs are valid this cycle.
- and_array_in  in  [DIMS_PER_CC-1:0] x [0:NUM_CLASSES-1]  per-class AND vectors for segment query_ctr.
- query_ctr  out  4  segment index presented to the AND array.
- busy  out  1  high in ACCUM and SEARCH.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts the result.
- result_class  out  5  winning class index, 0..NUM_CLASSES-1.
- result_score  out  SCORE_W  winning popcount sum.

Behaviour:
- Reset (rst_n=0 at a clock edge, from any state including mid-ACCUM or mid-SEARCH):
  - Next state is IDLE.
  - query_ctr, busy, result_valid, result_class, result_score and all accumulators are 0.
  - The search index and best registers are 0.
- State machine: IDLE -> ACCUM -> SEARCH -> DONE -> IDLE.
- IDLE:
  - start=1 clears all NUM_CLASSES accumulators, sets query_ctr=0 and moves to ACCUM.
  - start=0 holds.
- ACCUM, on a cycle with seg_valid=1:
  - acc[i] += popcount(and_array_in[i]) for every class i.
  - If query_ctr==SEQ_CYCLE_COUNT-1: set search index to 0 and go to SEARCH. query_ctr returns to 0.
  - Otherwise query_ctr increments.
- ACCUM, on a cycle with seg_valid=0: accumulators and query_ctr hold.
- start is ignored outside IDLE (including DONE). It is never queued.
- SEARCH handles one class per cycle:
  - idx 0 loads best_score=acc[0], best_class=0.
  - Each later idx replaces the best only if acc[idx] > best_score (strictly greater). Ties therefore resolve to the lowest index.
  - After idx==NUM_CLASSES-1, go to DONE.
- DONE:
  - result_valid=1; result_class and result_score are driven from the best registers and stay stable.
  - A cycle with result_valid & result_ready returns to IDLE, and result_valid drops on the next cycle.
- Latency: with seg_valid continuously high, result_valid rises SEQ_CYCLE_COUNT+NUM_CLASSES cycles after the edge that samples start (36 at defaults). Each seg_valid=0 cycle in ACCUM adds one cycle.
- Width rules:
  - Popcount of one segment is at most DIMS_PER_CC.
  - The accumulator cannot overflow SCORE_W by construction.
  - Comparisons are unsigned.
- query_ctr values: it only takes 0..SEQ_CYCLE_COUNT-1 and is 0 whenever the block is not in ACCUM. The AND array's default branch is never relied on.
- and_array_in is ignored outside ACCUM and on seg_valid=0 cycles.
- busy = (state==ACCUM) | (state==SEARCH).

Test Plan:
(All scenarios use DIMS_PER_CC=8, SEQ_CYCLE_COUNT=10, NUM_CLASSES=26.)
1. All and_array_in=0, seg_valid constantly 1, start pulse -> result_valid rises exactly 36 cycles after start is sampled; result_class=0, result_score=0; query_ctr steps 0..9 then returns to 0.
2. Class 7 is 8'hFF in every segment and all other classes are 8'h0F -> result_class=7, result_score=80, with result_ready held high. Then check that result_valid drops on the cycle after acceptance and busy=0.
3. Classes 3 and 20 are both 8'hF0 in every segment and all others are 0 -> tie at score 40; result_class=3.
4. seg_valid deasserted for 3 cycles at query_ctr=4 -> query_ctr holds at 4 and accumulators are unchanged during the gap; the result is identical to the no-gap run, delivered 3 cycles later (39).
5. rst_n=0 for one cycle while query_ctr=6 -> the next cycle shows IDLE with all outputs 0. A fresh start then produces the correct result with no residue from the aborted query.
6. In DONE, result_ready=0 for 5 cycles and start pulsed twice -> result_valid, result_class and result_score are stable and both starts are ignored; result_ready=1 then returns the block to IDLE, and a later start is accepted.
